rv32_ctrl_fsm: RTL
==================

Name: rv32_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32 core. It sequences instruction fetch, the clocked decoder stage, execute, memory and write-back. It owns the PC, the instruction register feeding the decoder, the retire counter and minimal trap state (mepc/mcause). It sits between the instruction/data memory handshakes and the decoder/ALU/register-file datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded on any trap

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_ready  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
instr  out  32  instruction register, drives decoder instruction input
dec_opcode  in  7  decoder opcode
dec_funct3  in  3  decoder funct3
dec_trap  in  1  decoder illegal-instruction flag
dec_ecall_break  in  1  decoder ecall/ebreak flag
alu_br_taken  in  1  branch condition true
next_pc_target  in  32  jump/branch target from datapath
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load
dmem_ready  in  1  data access complete this cycle
rf_we  out  1  register-file write enable
pc  out  32  current PC
retire  out  1  one-cycle pulse per retired instruction
instret  out  32  retired-instruction counter
trap_taken  out  1  one-cycle pulse on trap entry
mepc  out  32  PC of trapping instruction
mcause  out  32  trap cause
state  out  3  current FSM state, for debug

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=FETCH, pc=RESET_PC, instr=32'h00000013 (NOP).
  - instret=0, mepc=0, mcause=0.
  - All strobes 0: imem_req, dmem_req, dmem_we, rf_we, retire, trap_taken.
  - Reset asserted mid-MEM or mid-FETCH abandons the access; the req strobe is 0 from the next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Stay in FETCH while imem_ready=0 (unbounded stall).
  - On imem_ready=1: instr<=imem_rdata, go to DECODE. Zero-wait ready in the same cycle is legal.
- DECODE: single cycle while the decoder registers instr, then EXEC.
- EXEC, in priority order:
  1. dec_trap → TRAP, cause 2.
  2. dec_ecall_break → TRAP, cause 3 if instr[20]=1 (ebreak), else cause 11 (ecall).
  3. Opcode LOAD (0000011) or STORE (0100011) → MEM.
  4. Anything else → WB.
- MEM:
  - dmem_req=1, dmem_we=1 for STORE.
  - Hold until dmem_ready=1.
  - Load → WB.
  - Store: pc<=pc+4, retire pulse, go to FETCH.
- WB:
  - rf_we=1 for LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD, and SYSTEM with funct3!=0. rf_we=0 for BRANCH.
  - Next PC: next_pc_target for JAL, JALR, or BRANCH with alu_br_taken=1; otherwise pc+4.
  - If the selected target has [1:0]!=0: no rf_we, no retire, go to TRAP with cause 0.
  - Otherwise: retire pulse, go to FETCH.
- TRAP:
  - mepc<=pc, mcause<=cause, pc<=TRAP_VEC.
  - trap_taken=1 for exactly this cycle, then FETCH.
  - A trapping instruction does not retire.
- Arithmetic:
  - pc+4 wraps modulo 2^32: 32'hFFFF_FFFC → 0.
  - instret wraps from 32'hFFFF_FFFF → 0.
- Latency with zero-wait memories:
  - ALU, jump, branch: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Trap: 4 cycles to trap_taken.
- retire and trap_taken are never asserted in the same cycle.

Decomposition:
- Package rv32_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM);
  - FSM state encoding;
  - cause codes (0, 2, 3, 11);
  - NOP constant.
- One sub-module, rv32_next_pc: combinational next-PC mux plus misalignment flag. All state stays in rv32_ctrl_fsm.

Test Plan:
- Reset, then imem returns 32'h4d228213 (addi) with zero wait → rf_we=1 in cycle 4, pc=4, instret=1.
- 32'h4d202203 (lw) with dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, rf_we in the following WB, pc=4.
- 32'h4c402923 (sw) → dmem_we=1, rf_we never 1, retire on the dmem_ready cycle, pc=4.
- 32'h004000ef (jal) with next_pc_target=32'h0C → pc=32'h0C, rf_we=1. Same instruction with target 32'h0E → trap_taken, mcause=0, mepc=0, pc=32'h100.
- 32'h00000073 (ecall) → mcause=11; 32'h00100073 (ebreak) → mcause=3; 32'ha5a5a5a5 → mcause=2. Each gives pc=32'h100 and leaves instret unchanged.
- rst pulsed during MEM with dmem_ready=0 → next cycle state=FETCH, pc=0, dmem_req=0; pc at 32'hFFFF_FFFC executing addi wraps to 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared constants for the RV32 control sequencer: opcodes, FSM states, trap causes.
// Pure definitions plus one helper deciding whether an instruction writes rd.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [31:0] CAUSE_MISALIGN = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
    localparam logic [31:0] CAUSE_BREAK    = 32'd3;
    localparam logic [31:0] CAUSE_ECALL    = 32'd11;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // SYSTEM with funct3==0 (ecall/ebreak/mret family) never writes rd.
    function automatic logic writes_rd(input logic [6:0] opcode, input logic [2:0] funct3);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_OP, OPC_OP_IMM, OPC_LOAD: writes_rd = 1'b1;
            OPC_SYSTEM:                   writes_rd = (funct3 != 3'd0);
            default:                      writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32_next_pc.sv
// Combinational next-PC select for write-back: jump/taken-branch target or pc+4.
// Also flags a target that is not word aligned.
module rv32_next_pc
    import rv32_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic        i_br_taken,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_target,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    logic w_jump;

    always_comb begin
        w_jump       = (i_opcode == OPC_JAL) || (i_opcode == OPC_JALR) ||
                       ((i_opcode == OPC_BRANCH) && i_br_taken);
        o_next_pc    = w_jump ? i_target : (i_pc + 32'd4);
        o_misaligned = (o_next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/rv32_ctrl_fsm.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP, owns pc, instr, instret, mepc/mcause.
// Zero-wait latency 4 cycles (5 for loads and WB traps); stalls indefinitely on imem/dmem ready.
module rv32_ctrl_fsm
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [6:0]  dec_opcode,
    input  logic [2:0]  dec_funct3,
    input  logic        dec_trap,
    input  logic        dec_ecall_break,
    input  logic        alu_br_taken,
    input  logic [31:0] next_pc_target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        retire,
    output logic [31:0] instret,
    output logic        trap_taken,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [2:0]  state
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instret;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_cause;

    logic [31:0] w_next_pc;
    logic        w_misaligned;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_run;

    rv32_next_pc u_next_pc (
        .i_opcode     (dec_opcode),
        .i_br_taken   (alu_br_taken),
        .i_pc         (r_pc),
        .i_target     (next_pc_target),
        .o_next_pc    (w_next_pc),
        .o_misaligned (w_misaligned)
    );

    assign w_is_store = (dec_opcode == OPC_STORE);
    assign w_is_mem   = w_is_store || (dec_opcode == OPC_LOAD);

    // Strobes are held low for the whole reset cycle so an abandoned access never leaks out.
    always_comb begin
        w_run      = !rst;
        imem_req   = w_run && (r_state == ST_FETCH);
        dmem_req   = w_run && (r_state == ST_MEM);
        dmem_we    = dmem_req && w_is_store;
        rf_we      = w_run && (r_state == ST_WB) && !w_misaligned &&
                     writes_rd(dec_opcode, dec_funct3);
        retire     = w_run && (((r_state == ST_WB) && !w_misaligned) ||
                               ((r_state == ST_MEM) && dmem_ready && w_is_store));
        trap_taken = w_run && (r_state == ST_TRAP);
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign instret   = r_instret;
    assign mepc      = r_mepc;
    assign mcause    = r_mcause;
    assign state     = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_instr   <= NOP;
            r_instret <= 32'd0;
            r_mepc    <= 32'd0;
            r_mcause  <= 32'd0;
            r_cause   <= 32'd0;
        end else begin
            if (retire) begin
                r_instret <= r_instret + 32'd1;
            end
            case (r_state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: r_state <= ST_EXEC;
                ST_EXEC: begin
                    if (dec_trap) begin
                        r_cause <= CAUSE_ILLEGAL;
                        r_state <= ST_TRAP;
                    end else if (dec_ecall_break) begin
                        r_cause <= r_instr[20] ? CAUSE_BREAK : CAUSE_ECALL;
                        r_state <= ST_TRAP;
                    end else if (w_is_mem) begin
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        if (w_is_store) begin
                            r_pc    <= r_pc + 32'd4;
                            r_state <= ST_FETCH;
                        end else begin
                            r_state <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    if (w_misaligned) begin
                        r_cause <= CAUSE_MISALIGN;
                        r_state <= ST_TRAP;
                    end else begin
                        r_pc    <= w_next_pc;
                        r_state <= ST_FETCH;
                    end
                end
                ST_TRAP: begin
                    r_mepc   <= r_pc;
                    r_mcause <= r_cause;
                    r_pc     <= TRAP_VEC;
                    r_state  <= ST_FETCH;
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

endmodule
